decode_execute_reg: RTL and testbench

//   ID/EX pipeline register between the decode stage (control unit + register file + immediate gen)
//   and the execute stage. Captures decoded control bits and operands each cycle, 1-cycle latency.

---
 rtl/decode_execute_reg_if.sv | 60 ++++++
 rtl/decode_execute_reg.sv | 121 ++++++++++++
 tb/tb_decode_execute_reg.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/decode_execute_reg_if.sv
// rtl/decode_execute_reg_if.sv - decode/execute boundary signal bundle for the ID/EX register
interface decode_execute_reg_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  // stage control
  logic              EN;
  logic              FLUSH;
  logic              STALL_D;

  // decode side
  logic              VALID_D;
  logic [1:0]        ALU_OP;
  logic [1:0]        ALU_SRC2;
  logic              BRN_COND;
  logic              MEM_WE;
  logic              DE_WE;
  logic              MEM_REG;
  logic [2:0]        FUNCT3_D;
  logic [REG_AW-1:0] RS1_D;
  logic [REG_AW-1:0] RS2_D;
  logic [REG_AW-1:0] RD_D;
  logic [XLEN-1:0]   RD1_D;
  logic [XLEN-1:0]   RD2_D;
  logic [XLEN-1:0]   IMM_D;
  logic [XLEN-1:0]   PC_D;

  // execute side
  logic              VALID_E;
  logic [1:0]        ALU_OP_E;
  logic [1:0]        ALU_SRC2_E;
  logic              BRN_COND_E;
  logic              MEM_WE_E;
  logic              DE_WE_E;
  logic              MEM_REG_E;
  logic [2:0]        FUNCT3_E;
  logic [REG_AW-1:0] RS1_E;
  logic [REG_AW-1:0] RS2_E;
  logic [REG_AW-1:0] RD_E;
  logic [XLEN-1:0]   RD1_E;
  logic [XLEN-1:0]   RD2_E;
  logic [XLEN-1:0]   IMM_E;
  logic [XLEN-1:0]   PC_E;

  // decode stage / pipeline controller drives D side and reads E side
  modport master (
    output EN, FLUSH, VALID_D, ALU_OP, ALU_SRC2, BRN_COND, MEM_WE, DE_WE, MEM_REG,
           FUNCT3_D, RS1_D, RS2_D, RD_D, RD1_D, RD2_D, IMM_D, PC_D,
    input  STALL_D, VALID_E, ALU_OP_E, ALU_SRC2_E, BRN_COND_E, MEM_WE_E, DE_WE_E,
           MEM_REG_E, FUNCT3_E, RS1_E, RS2_E, RD_E, RD1_E, RD2_E, IMM_E, PC_E
  );

  // the pipeline register itself
  modport slave (
    input  EN, FLUSH, VALID_D, ALU_OP, ALU_SRC2, BRN_COND, MEM_WE, DE_WE, MEM_REG,
           FUNCT3_D, RS1_D, RS2_D, RD_D, RD1_D, RD2_D, IMM_D, PC_D,
    output STALL_D, VALID_E, ALU_OP_E, ALU_SRC2_E, BRN_COND_E, MEM_WE_E, DE_WE_E,
           MEM_REG_E, FUNCT3_E, RS1_E, RS2_E, RD_E, RD1_E, RD2_E, IMM_E, PC_E
  );
endinterface

// File: rtl/decode_execute_reg.sv
// rtl/decode_execute_reg.sv - ID/EX pipeline register with stall, flush and optional load-use bubble (LOAD_USE_DETECT_EN)
`ifndef ALU_SRC1
`define ALU_SRC1 2'b00
`endif

module decode_execute_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  decode_execute_reg_if.slave     bus
);

  typedef struct packed {
    logic              valid;
    logic [1:0]        alu_op;
    logic [1:0]        alu_src2;
    logic              brn_cond;
    logic              mem_we;
    logic              de_we;
    logic              mem_reg;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
  } ex_stage_t;

  ex_stage_t ex_q;
  ex_stage_t ex_d;
  ex_stage_t ex_load;
  logic      hazard;

`ifdef LOAD_USE_DETECT_EN
  logic      rs2_used;

  // load in E whose rd feeds a source of the valid instruction in D
  always_comb begin
    rs2_used = (bus.ALU_SRC2 == `ALU_SRC1) | bus.BRN_COND | bus.MEM_WE;
    hazard   = bus.VALID_D & ex_q.valid & ex_q.mem_reg & (ex_q.rd != '0) &
               ((ex_q.rd == bus.RS1_D) | (rs2_used & (ex_q.rd == bus.RS2_D)));
  end
`else
  // no load-use detection in this build; bubbles come only from FLUSH
  always_comb begin
    hazard = 1'b0;
  end
`endif

  // a redirect makes the D instruction dead, so it must never be held
  always_comb begin
    bus.STALL_D = hazard & ~bus.FLUSH;
  end

  // capture D side; side-effect bits of an invalid instruction are forced low
  always_comb begin
    ex_load          = '0;
    ex_load.valid    = bus.VALID_D;
    ex_load.alu_op   = bus.ALU_OP;
    ex_load.alu_src2 = bus.ALU_SRC2;
    ex_load.brn_cond = bus.BRN_COND & bus.VALID_D;
    ex_load.mem_we   = bus.MEM_WE   & bus.VALID_D;
    ex_load.de_we    = bus.DE_WE    & bus.VALID_D;
    ex_load.mem_reg  = bus.MEM_REG  & bus.VALID_D;
    ex_load.funct3   = bus.FUNCT3_D;
    ex_load.rs1      = bus.RS1_D;
    ex_load.rs2      = bus.RS2_D;
    ex_load.rd       = bus.RD_D;
    ex_load.rd1      = bus.RD1_D;
    ex_load.rd2      = bus.RD2_D;
    ex_load.imm      = bus.IMM_D;
    ex_load.pc       = bus.PC_D;
  end

  // next E state: flush beats hold, hold beats hazard bubble, bubble beats load
  always_comb begin
    ex_d = ex_q;
    if (bus.FLUSH) begin
      ex_d = '0;
    end else if (!bus.EN) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = '0;
    end else begin
      ex_d = ex_load;
    end
  end

  // E-stage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // drive E-side outputs straight from the flops
  always_comb begin
    bus.VALID_E    = ex_q.valid;
    bus.ALU_OP_E   = ex_q.alu_op;
    bus.ALU_SRC2_E = ex_q.alu_src2;
    bus.BRN_COND_E = ex_q.brn_cond;
    bus.MEM_WE_E   = ex_q.mem_we;
    bus.DE_WE_E    = ex_q.de_we;
    bus.MEM_REG_E  = ex_q.mem_reg;
    bus.FUNCT3_E   = ex_q.funct3;
    bus.RS1_E      = ex_q.rs1;
    bus.RS2_E      = ex_q.rs2;
    bus.RD_E       = ex_q.rd;
    bus.RD1_E      = ex_q.rd1;
    bus.RD2_E      = ex_q.rd2;
    bus.IMM_E      = ex_q.imm;
    bus.PC_E       = ex_q.pc;
  end

endmodule

// File: tb/tb_decode_execute_reg.sv
// tb/tb_decode_execute_reg.sv - directed self-checking bench for decode_execute_reg
`ifndef ALU_SRC1
`define ALU_SRC1 2'b00
`endif

module tb_decode_execute_reg;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  decode_execute_reg_if #(.XLEN(32), .REG_AW(5)) bus ();

  decode_execute_reg #(.XLEN(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [1:0] aop, input logic [1:0] asrc,
                       input logic brn, input logic mwe, input logic dwe, input logic mrg,
                       input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic [31:0] pc);
    bus.VALID_D  = v;
    bus.ALU_OP   = aop;
    bus.ALU_SRC2 = asrc;
    bus.BRN_COND = brn;
    bus.MEM_WE   = mwe;
    bus.DE_WE    = dwe;
    bus.MEM_REG  = mrg;
    bus.FUNCT3_D = f3;
    bus.RS1_D    = rs1;
    bus.RS2_D    = rs2;
    bus.RD_D     = rd;
    bus.RD1_D    = rd1;
    bus.RD2_D    = rd2;
    bus.IMM_D    = imm;
    bus.PC_D     = pc;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst       = 1'b1;
    bus.EN    = 1'b0;
    bus.FLUSH = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // reset state
    chk("rst_valid_e", {31'd0, bus.VALID_E}, 32'd0);
    chk("rst_rd1_e", bus.RD1_E, 32'd0);
    chk("rst_stall_d", {31'd0, bus.STALL_D}, 32'd0);
    rst = 1'b0;
    tick();

    // 1) pass-through
    bus.EN = 1'b1;
    set_d(1, 2'b01, 2'b01, 0, 0, 1, 0, 3'd2, 5'd1, 5'd2, 5'd5,
          32'h1234, 32'h55, 32'hFFFF_FFFC, 32'h100);
    tick();
    chk("pt_rd1_e", bus.RD1_E, 32'h1234);
    chk("pt_imm_e", bus.IMM_E, 32'hFFFF_FFFC);
    chk("pt_de_we_e", {31'd0, bus.DE_WE_E}, 32'd1);
    chk("pt_rd_e", {27'd0, bus.RD_E}, 32'd5);
    chk("pt_valid_e", {31'd0, bus.VALID_E}, 32'd1);
    chk("pt_pc_e", bus.PC_E, 32'h100);
    chk("pt_funct3_e", {29'd0, bus.FUNCT3_E}, 32'd2);

    // 2) hold for three cycles while D changes
    bus.EN = 1'b0;
    set_d(1, 2'b11, 2'b10, 1, 1, 0, 1, 3'd7, 5'd9, 5'd10, 5'd11,
          32'hDEAD, 32'hBEEF, 32'h8, 32'h300);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_rd1_e", bus.RD1_E, 32'h1234);
      chk("hold_rd_e", {27'd0, bus.RD_E}, 32'd5);
      chk("hold_mem_we_e", {31'd0, bus.MEM_WE_E}, 32'd0);
    end

    // invalid instruction: control loaded, side-effect bits gated
    bus.EN = 1'b1;
    set_d(0, 2'b10, 2'b01, 1, 1, 1, 1, 3'd3, 5'd4, 5'd6, 5'd12,
          32'hAAAA, 32'h0, 32'h0, 32'h400);
    tick();
    chk("inv_valid_e", {31'd0, bus.VALID_E}, 32'd0);
    chk("inv_side_fx", {28'd0, bus.BRN_COND_E, bus.MEM_WE_E, bus.DE_WE_E, bus.MEM_REG_E}, 32'd0);
    chk("inv_alu_op_e", {30'd0, bus.ALU_OP_E}, 32'd2);
    chk("inv_rd1_e", bus.RD1_E, 32'hAAAA);

    // 3) flush beats hold
    set_d(1, 2'b00, 2'b01, 0, 1, 0, 0, 3'd2, 5'd2, 5'd3, 5'd0,
          32'h10, 32'h20, 32'h4, 32'h500);
    tick();
    chk("st_mem_we_e", {31'd0, bus.MEM_WE_E}, 32'd1);
    bus.EN    = 1'b0;
    bus.FLUSH = 1'b1;
    set_d(1, 2'b00, 2'b01, 0, 1, 0, 0, 3'd2, 5'd2, 5'd3, 5'd0,
          32'h11, 32'h21, 32'h8, 32'h504);
    tick();
    chk("fl_valid_e", {31'd0, bus.VALID_E}, 32'd0);
    chk("fl_mem_we_e", {31'd0, bus.MEM_WE_E}, 32'd0);
    chk("fl_rd1_e", bus.RD1_E, 32'd0);
    bus.FLUSH = 1'b0;
    bus.EN    = 1'b1;

    // 4) load-use: lw x7 then add using x7 as rs2
    set_d(1, 2'b00, 2'b01, 0, 0, 1, 1, 3'd2, 5'd1, 5'd0, 5'd7,
          32'h0, 32'h0, 32'h0, 32'h600);
    tick();
    chk("lw_mem_reg_e", {31'd0, bus.MEM_REG_E}, 32'd1);
    set_d(1, 2'b00, `ALU_SRC1, 0, 0, 1, 0, 3'd0, 5'd3, 5'd7, 5'd8,
          32'h11, 32'h22, 32'h0, 32'h604);
    #1;
`ifdef LOAD_USE_DETECT_EN
    chk("lu_stall_on", {31'd0, bus.STALL_D}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, bus.VALID_E}, 32'd0);
    chk("lu_bubble_rd", {27'd0, bus.RD_E}, 32'd0);
    chk("lu_stall_clear", {31'd0, bus.STALL_D}, 32'd0);
    tick();
`else
    chk("lu_stall_off", {31'd0, bus.STALL_D}, 32'd0);
    tick();
`endif
    chk("lu_add_valid", {31'd0, bus.VALID_E}, 32'd1);
    chk("lu_add_rd", {27'd0, bus.RD_E}, 32'd8);
    chk("lu_add_rd1", bus.RD1_E, 32'h11);

    // 5a) load to x0 never stalls
    set_d(1, 2'b00, 2'b01, 0, 0, 1, 1, 3'd2, 5'd1, 5'd0, 5'd0,
          32'h0, 32'h0, 32'h0, 32'h700);
    tick();
    set_d(1, 2'b00, `ALU_SRC1, 0, 0, 1, 0, 3'd0, 5'd0, 5'd0, 5'd4,
          32'h0, 32'h0, 32'h0, 32'h704);
    #1;
    chk("x0_no_stall", {31'd0, bus.STALL_D}, 32'd0);

    // 5b) addi: rs2 field matches but is not used
    set_d(1, 2'b00, 2'b01, 0, 0, 1, 1, 3'd2, 5'd1, 5'd0, 5'd9,
          32'h0, 32'h0, 32'h0, 32'h800);
    tick();
    set_d(1, 2'b00, 2'b01, 0, 0, 1, 0, 3'd0, 5'd2, 5'd9, 5'd5,
          32'h0, 32'h0, 32'h7, 32'h804);
    #1;
    chk("addi_no_stall", {31'd0, bus.STALL_D}, 32'd0);

    // rs1 dependency, then flush suppresses the stall
    set_d(1, 2'b00, 2'b01, 0, 0, 1, 0, 3'd0, 5'd9, 5'd0, 5'd5,
          32'h0, 32'h0, 32'h7, 32'h804);
    #1;
`ifdef LOAD_USE_DETECT_EN
    chk("rs1_stall", {31'd0, bus.STALL_D}, 32'd1);
`else
    chk("rs1_stall", {31'd0, bus.STALL_D}, 32'd0);
`endif
    bus.FLUSH = 1'b1;
    #1;
    chk("flush_no_stall", {31'd0, bus.STALL_D}, 32'd0);
    bus.FLUSH = 1'b0;

    // hold while a hazard is pending: no bubble injected
    bus.EN = 1'b0;
    tick();
    chk("hz_hold_rd", {27'd0, bus.RD_E}, 32'd9);
    chk("hz_hold_mem_reg", {31'd0, bus.MEM_REG_E}, 32'd1);

    // 6) async reset mid-cycle during stall
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid_e", {31'd0, bus.VALID_E}, 32'd0);
    chk("ar_rd_e", {27'd0, bus.RD_E}, 32'd0);
    chk("ar_mem_reg_e", {31'd0, bus.MEM_REG_E}, 32'd0);
    chk("ar_pc_e", bus.PC_E, 32'd0);
    chk("ar_stall_d", {31'd0, bus.STALL_D}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
